scariv_bru_multi_pipe: RTL and testbench
========================================

# scariv_bru_multi_pipe

Parametrised multi-lane branch resolution pipeline: N_LANES independent 3-stage branch lanes (EX0 issue, EX1 compare/target, EX2 report), for wider-issue cores. Adds behaviour the single-lane pipe lacks:
- cross-lane selection of the oldest mispredict into one flush request;
- same-cycle and next-cycle squash of younger in-flight branches;
- a global flush input.

Sits between the BRU reservation stations and the branch-update/commit logic. Operands arrive already read.

## Interface
Parameters:
- N_LANES, 2, lane count, 1..4
- XLEN, 64, operand/result width
- VADDR_W, 39, virtual address width (≤ XLEN)
- AGE_W, 7, age tag width; MSB is the wrap bit

Ports; all lane ports are packed arrays [N_LANES]:
- i_clk  in  1  clock, single domain
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  N  issue valid per lane (EX0)
- i_op  in  N×4  bru_op_t: EQ, NE, LT, GE, LTU, GEU, JAL, JALR, AUIPC
- i_rs1, i_rs2  in  N×XLEN  operands
- i_pc  in  N×VADDR_W  instruction PC
- i_imm  in  N×32  sign-extended, pre-decoded offset
- i_is_rvc  in  N  compressed instruction (link = PC+2)
- i_wr_rd  in  N  write link/AUIPC result
- i_pred_taken  in  N  frontend prediction
- i_pred_target  in  N×VADDR_W  predicted target
- i_age  in  N×AGE_W  program-order tag
- i_flush  in  1  commit flush; kills everything in flight
- o_wr_valid  out  N  result write enable (EX2)
- o_wr_data  out  N×XLEN  link or AUIPC value
- o_done  out  N  completion report
- o_done_age  out  N×AGE_W  completing tag
- o_upd_valid  out  N  branch-predictor update (non-AUIPC, surviving)
- o_upd_taken  out  N  resolved direction
- o_upd_target  out  N×VADDR_W  resolved next PC
- o_flush_valid  out  1  oldest mispredict this cycle
- o_flush_age  out  AGE_W  its tag
- o_flush_target  out  VADDR_W  redirect PC

## Operation
- **Age order.** a is older than b when:
  - MSBs equal and low bits of a < low bits of b; or
  - MSBs differ and low bits of a > low bits of b.
  - Equal tags never coexist.
- **EX1 computes:**
  - taken: conditional ops per signed/unsigned compare; JAL/JALR are 1; AUIPC is 0.
  - target:
    - SB/JAL: pc + imm.
    - JALR: (rs1 + imm) with bit0 cleared, truncated to VADDR_W.
  - fallthrough: pc + 2 or pc + 4.
  - wr_data:
    - AUIPC: sext(pc) + imm.
    - Otherwise: sext(fallthrough).
- **EX1 mispredict** = (taken ≠ pred_taken) | (taken & target ≠ pred_target). Always 0 for AUIPC.
- **EX2 outputs:**
  - o_upd_target = taken ? target : fallthrough.
  - o_wr_valid = surviving & wr_rd.
  - o_done = surviving.
- **Flush selection:** among surviving EX2 lanes with mispredict, pick the oldest. Drive o_flush_valid, o_flush_age, o_flush_target (= o_upd_target of that lane).
- **Squash**, when o_flush_valid is high with age F:
  - Same cycle: EX2 lanes younger than F drop done/wr/upd outputs.
  - Next cycle: EX1 entries younger than F, and EX0 inputs younger than F, are not advanced (valid cleared).
  - The mispredicting lane itself completes normally.
- **i_flush:**
  - Same cycle: all EX2 outputs are gated to 0, including o_flush_valid.
  - EX1 and EX0 are cleared at the next edge.
- **Reset:** every valid register is cleared, so every output is 0. Data registers also reset to 0.

## Timing
- Issue sampled at edge T. EX1 register state is valid in cycle T+1; EX2 in cycle T+2.
- Outputs are combinational from EX2 registers. Latency is 2 cycles; throughput is 1 op per lane per cycle, with no backpressure.
- Squash compares use the current cycle's o_flush_age, so squash takes effect at the next edge with no bubble.
- Two lanes mispredicting in the same cycle: only the oldest is reported; younger ones are squashed.
- Wrap-around: tags crossing the MSB toggle still order correctly.
- i_reset asserted mid-operation: all in-flight entries are discarded at that edge. No output is valid in the following cycle.

## Structure
- scariv_bru_pkg gains:
  - bru_op_t enum;
  - function is_older(a, b) on AGE_W tags;
  - parameter-free constants for the op encodings.
- One natural sub-module, scariv_bru_lane (EX1/EX2 registers and arithmetic for one lane), instantiated N_LANES times.
- The top module holds oldest-mispredict selection and squash fan-out.

## Test plan
- **Single BEQ.** Lane 0, rs1 = rs2 = 5, pc = 0x1000, imm = 0x40, pred_taken = 1, pred_target = 0x1040, age 3.
  - At T+2: o_upd_taken = 1, o_upd_target = 0x1040, o_flush_valid = 0, o_done_age = 3.
- **JALR with link.** rs1 = 0x2003, imm = 4, is_rvc = 0, pc = 0x500, wr_rd = 1, pred_target = 0x2000.
  - Result: target 0x2006, o_wr_data = 0x504, o_flush_valid = 1, o_flush_target = 0x2006.
- **Dual mispredict.** Lane 0 age 10 and lane 1 age 8 both mispredict in the same cycle.
  - o_flush_age = 8; lane 0 has o_done = 0 and o_upd_valid = 0.
- **Squash of younger op.** Mispredict at age 20 shown in EX2 while EX1 holds age 21 and EX0 issues age 19 and age 22.
  - Next cycle: only age 19 advances.
- **Wrap-around.** Flush age 0x7E (MSB 1) with EX1 holding age 0x01 (MSB 0).
  - Age 0x01 is treated as younger and squashed.
- **Flush and reset.** Assert i_flush with all stages full: outputs are 0 the same cycle, and no valid appears for 2 cycles.
  - Repeat with i_reset instead: all outputs are 0 the cycle after the reset edge.

Source files
------------

// File: rtl/scariv_bru_pkg.sv
// scariv_bru_pkg: branch-unit op encodings, op enum and program-order age comparison
// Ports: none (package). is_older orders wrapping age tags of up to AGE_W_MAX bits.
package scariv_bru_pkg;
  localparam logic [3:0] OP_EQ    = 4'd0;
  localparam logic [3:0] OP_NE    = 4'd1;
  localparam logic [3:0] OP_LT    = 4'd2;
  localparam logic [3:0] OP_GE    = 4'd3;
  localparam logic [3:0] OP_LTU   = 4'd4;
  localparam logic [3:0] OP_GEU   = 4'd5;
  localparam logic [3:0] OP_JAL   = 4'd6;
  localparam logic [3:0] OP_JALR  = 4'd7;
  localparam logic [3:0] OP_AUIPC = 4'd8;
  localparam int AGE_W_MAX = 16;
  typedef enum logic [3:0] {
    BRU_EQ    = OP_EQ,
    BRU_NE    = OP_NE,
    BRU_LT    = OP_LT,
    BRU_GE    = OP_GE,
    BRU_LTU   = OP_LTU,
    BRU_GEU   = OP_GEU,
    BRU_JAL   = OP_JAL,
    BRU_JALR  = OP_JALR,
    BRU_AUIPC = OP_AUIPC
  } bru_op_t;
  // The MSB of a w-bit tag is a wrap bit: when it differs the ordering of the low bits inverts.
  function automatic logic is_older(input logic [AGE_W_MAX-1:0] a, input logic [AGE_W_MAX-1:0] b, input int w);
    logic [AGE_W_MAX-1:0] h;
    logic [AGE_W_MAX-1:0] m;
    h = AGE_W_MAX'(1) << (w - 1);
    m = h - AGE_W_MAX'(1);
    return ((a & h) == (b & h)) ? ((a & m) < (b & m)) : ((a & m) > (b & m));
  endfunction
endpackage

// File: rtl/scariv_bru_lane.sv
// scariv_bru_lane: one branch lane, EX1 register + compare/target arithmetic, EX2 result register
// Ports: i_valid/i_* EX0 issue (pre-squashed by the top), i_kill drops the EX1 entry at the edge,
// o_ex1_age for squash compares, o_* raw EX2 state (gated into outputs by the top).
module scariv_bru_lane
  import scariv_bru_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int VADDR_W = 39,
  parameter int AGE_W   = 7
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic               i_kill,
  input  logic [3:0]         i_op,
  input  logic [XLEN-1:0]    i_rs1,
  input  logic [XLEN-1:0]    i_rs2,
  input  logic [VADDR_W-1:0] i_pc,
  input  logic [31:0]        i_imm,
  input  logic               i_is_rvc,
  input  logic               i_wr_rd,
  input  logic               i_pred_taken,
  input  logic [VADDR_W-1:0] i_pred_target,
  input  logic [AGE_W-1:0]   i_age,
  output logic [AGE_W-1:0]   o_ex1_age,
  output logic               o_valid,
  output logic               o_taken,
  output logic [VADDR_W-1:0] o_target,
  output logic               o_wr_rd,
  output logic [XLEN-1:0]    o_wr_data,
  output logic               o_mispred,
  output logic               o_upd,
  output logic [AGE_W-1:0]   o_age
);
  typedef struct packed {
    logic               valid;
    bru_op_t            op;
    logic [XLEN-1:0]    rs1;
    logic [XLEN-1:0]    rs2;
    logic [VADDR_W-1:0] pc;
    logic [31:0]        imm;
    logic               is_rvc;
    logic               wr_rd;
    logic               pred_taken;
    logic [VADDR_W-1:0] pred_target;
    logic [AGE_W-1:0]   age;
  } ex1_t;
  typedef struct packed {
    logic               valid;
    logic               taken;
    logic [VADDR_W-1:0] target;
    logic               wr_rd;
    logic [XLEN-1:0]    wr_data;
    logic               mispred;
    logic               upd;
    logic [AGE_W-1:0]   age;
  } ex2_t;
  ex1_t ex1_d, ex1_q;
  ex2_t ex2_d, ex2_q;
  logic               taken;
  logic               is_auipc;
  logic               mispred;
  logic [VADDR_W-1:0] target;
  logic [VADDR_W-1:0] fallthrough;
  logic [XLEN-1:0]    pc_sum;
  always_comb begin
    ex1_d.valid       = i_valid;
    ex1_d.op          = bru_op_t'(i_op);
    ex1_d.rs1         = i_rs1;
    ex1_d.rs2         = i_rs2;
    ex1_d.pc          = i_pc;
    ex1_d.imm         = i_imm;
    ex1_d.is_rvc      = i_is_rvc;
    ex1_d.wr_rd       = i_wr_rd;
    ex1_d.pred_taken  = i_pred_taken;
    ex1_d.pred_target = i_pred_target;
    ex1_d.age         = i_age;
    is_auipc = ex1_q.op == BRU_AUIPC;
    taken = 1'b0;
    case (ex1_q.op)
      BRU_EQ:            taken = ex1_q.rs1 == ex1_q.rs2;
      BRU_NE:            taken = ex1_q.rs1 != ex1_q.rs2;
      BRU_LT:            taken = $signed(ex1_q.rs1) < $signed(ex1_q.rs2);
      BRU_GE:            taken = $signed(ex1_q.rs1) >= $signed(ex1_q.rs2);
      BRU_LTU:           taken = ex1_q.rs1 < ex1_q.rs2;
      BRU_GEU:           taken = ex1_q.rs1 >= ex1_q.rs2;
      BRU_JAL, BRU_JALR: taken = 1'b1;
      default:           taken = 1'b0;
    endcase
    pc_sum      = XLEN'($signed(ex1_q.pc)) + XLEN'($signed(ex1_q.imm));
    fallthrough = ex1_q.pc + (ex1_q.is_rvc ? VADDR_W'(2) : VADDR_W'(4));
    target      = ex1_q.op == BRU_JALR ? VADDR_W'(ex1_q.rs1 + XLEN'($signed(ex1_q.imm))) & ~VADDR_W'(1)
                                       : VADDR_W'(pc_sum);
    mispred     = ~is_auipc & ((taken != ex1_q.pred_taken) | (taken & (target != ex1_q.pred_target)));
    ex2_d.valid   = ex1_q.valid & ~i_kill;
    ex2_d.taken   = taken;
    ex2_d.target  = taken ? target : fallthrough;
    ex2_d.wr_rd   = ex1_q.wr_rd;
    ex2_d.wr_data = is_auipc ? pc_sum : XLEN'($signed(fallthrough));
    ex2_d.mispred = mispred;
    ex2_d.upd     = ~is_auipc;
    ex2_d.age     = ex1_q.age;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ex1_q <= '0;
      ex2_q <= '0;
    end else begin
      ex1_q <= ex1_d;
      ex2_q <= ex2_d;
    end
  end
  assign o_ex1_age = ex1_q.age;
  assign o_valid   = ex2_q.valid;
  assign o_taken   = ex2_q.taken;
  assign o_target  = ex2_q.target;
  assign o_wr_rd   = ex2_q.wr_rd;
  assign o_wr_data = ex2_q.wr_data;
  assign o_mispred = ex2_q.mispred;
  assign o_upd     = ex2_q.upd;
  assign o_age     = ex2_q.age;
endmodule

// File: rtl/scariv_bru_multi_pipe.sv
// scariv_bru_multi_pipe: N-lane 3-stage branch resolution with oldest-mispredict flush and younger squash
// Ports: i_* per-lane EX0 issue (packed [N_LANES]), i_flush global kill; o_wr/o_done/o_upd per-lane EX2
// reports; o_flush_* single redirect for the oldest surviving mispredict.
module scariv_bru_multi_pipe
  import scariv_bru_pkg::*;
#(
  parameter int N_LANES = 2,
  parameter int XLEN    = 64,
  parameter int VADDR_W = 39,
  parameter int AGE_W   = 7
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic [N_LANES-1:0]                i_valid,
  input  logic [N_LANES-1:0][3:0]           i_op,
  input  logic [N_LANES-1:0][XLEN-1:0]      i_rs1,
  input  logic [N_LANES-1:0][XLEN-1:0]      i_rs2,
  input  logic [N_LANES-1:0][VADDR_W-1:0]   i_pc,
  input  logic [N_LANES-1:0][31:0]          i_imm,
  input  logic [N_LANES-1:0]                i_is_rvc,
  input  logic [N_LANES-1:0]                i_wr_rd,
  input  logic [N_LANES-1:0]                i_pred_taken,
  input  logic [N_LANES-1:0][VADDR_W-1:0]   i_pred_target,
  input  logic [N_LANES-1:0][AGE_W-1:0]     i_age,
  input  logic                              i_flush,
  output logic [N_LANES-1:0]                o_wr_valid,
  output logic [N_LANES-1:0][XLEN-1:0]      o_wr_data,
  output logic [N_LANES-1:0]                o_done,
  output logic [N_LANES-1:0][AGE_W-1:0]     o_done_age,
  output logic [N_LANES-1:0]                o_upd_valid,
  output logic [N_LANES-1:0]                o_upd_taken,
  output logic [N_LANES-1:0][VADDR_W-1:0]   o_upd_target,
  output logic                              o_flush_valid,
  output logic [AGE_W-1:0]                  o_flush_age,
  output logic [VADDR_W-1:0]                o_flush_target
);
  logic [N_LANES-1:0]              ex2_valid, ex2_taken, ex2_wr_rd, ex2_mispred, ex2_upd, surv;
  logic [N_LANES-1:0][VADDR_W-1:0] ex2_target;
  logic [N_LANES-1:0][XLEN-1:0]    ex2_wr_data;
  logic [N_LANES-1:0][AGE_W-1:0]   ex2_age, ex1_age;
  logic                            sel_valid;
  logic [AGE_W-1:0]                sel_age;
  logic [VADDR_W-1:0]              sel_target;
  always_comb begin
    sel_valid  = 1'b0;
    sel_age    = '0;
    sel_target = '0;
    for (int i = 0; i < N_LANES; i++)
      if (ex2_valid[i] && ex2_mispred[i] &&
          (!sel_valid || is_older(AGE_W_MAX'(ex2_age[i]), AGE_W_MAX'(sel_age), AGE_W))) begin
        sel_valid  = 1'b1;
        sel_age    = ex2_age[i];
        sel_target = ex2_target[i];
      end
  end
  assign o_flush_valid  = sel_valid & ~i_flush;
  assign o_flush_age    = o_flush_valid ? sel_age : '0;
  assign o_flush_target = o_flush_valid ? sel_target : '0;
  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    // The selected lane itself is never younger than its own tag, so it survives.
    assign surv[l] = ex2_valid[l] & ~i_flush &
                     ~(sel_valid & is_older(AGE_W_MAX'(sel_age), AGE_W_MAX'(ex2_age[l]), AGE_W));
    scariv_bru_lane #(.XLEN(XLEN), .VADDR_W(VADDR_W), .AGE_W(AGE_W)) u_lane (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_valid       (i_valid[l] & ~i_flush &
                      ~(o_flush_valid & is_older(AGE_W_MAX'(sel_age), AGE_W_MAX'(i_age[l]), AGE_W))),
      .i_kill        (i_flush |
                      (o_flush_valid & is_older(AGE_W_MAX'(sel_age), AGE_W_MAX'(ex1_age[l]), AGE_W))),
      .i_op          (i_op[l]),
      .i_rs1         (i_rs1[l]),
      .i_rs2         (i_rs2[l]),
      .i_pc          (i_pc[l]),
      .i_imm         (i_imm[l]),
      .i_is_rvc      (i_is_rvc[l]),
      .i_wr_rd       (i_wr_rd[l]),
      .i_pred_taken  (i_pred_taken[l]),
      .i_pred_target (i_pred_target[l]),
      .i_age         (i_age[l]),
      .o_ex1_age     (ex1_age[l]),
      .o_valid       (ex2_valid[l]),
      .o_taken       (ex2_taken[l]),
      .o_target      (ex2_target[l]),
      .o_wr_rd       (ex2_wr_rd[l]),
      .o_wr_data     (ex2_wr_data[l]),
      .o_mispred     (ex2_mispred[l]),
      .o_upd         (ex2_upd[l]),
      .o_age         (ex2_age[l])
    );
    assign o_done[l]       = surv[l];
    assign o_done_age[l]   = surv[l] ? ex2_age[l] : '0;
    assign o_wr_valid[l]   = surv[l] & ex2_wr_rd[l];
    assign o_wr_data[l]    = o_wr_valid[l] ? ex2_wr_data[l] : '0;
    assign o_upd_valid[l]  = surv[l] & ex2_upd[l];
    assign o_upd_taken[l]  = o_upd_valid[l] & ex2_taken[l];
    assign o_upd_target[l] = o_upd_valid[l] ? ex2_target[l] : '0;
  end
endmodule

// File: tb/tb_scariv_bru_multi_pipe.sv
// tb_scariv_bru_multi_pipe: directed scoreboard bench for the 2-lane branch resolution pipe
module tb_scariv_bru_multi_pipe;
  logic             i_clk = 1'b0;
  logic             i_reset = 1'b1;
  logic             i_flush = 1'b0;
  logic [1:0]       i_valid = '0;
  logic [1:0][3:0]  i_op = '0;
  logic [1:0][63:0] i_rs1 = '0;
  logic [1:0][63:0] i_rs2 = '0;
  logic [1:0][38:0] i_pc = '0;
  logic [1:0][31:0] i_imm = '0;
  logic [1:0]       i_is_rvc = '0;
  logic [1:0]       i_wr_rd = '0;
  logic [1:0]       i_pred_taken = '0;
  logic [1:0][38:0] i_pred_target = '0;
  logic [1:0][6:0]  i_age = '0;
  logic [1:0]       o_wr_valid, o_done, o_upd_valid, o_upd_taken;
  logic [1:0][63:0] o_wr_data;
  logic [1:0][6:0]  o_done_age;
  logic [1:0][38:0] o_upd_target;
  logic             o_flush_valid;
  logic [6:0]       o_flush_age;
  logic [38:0]      o_flush_target;
  typedef struct {
    int          due;
    logic [6:0]  age;
    logic        wr;
    logic [63:0] wd;
    logic        upd;
    logic        tk;
    logic [38:0] tgt;
  } exp_t;
  exp_t sq0[$];
  exp_t sq1[$];
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  scariv_bru_multi_pipe #(.N_LANES(2), .XLEN(64), .VADDR_W(39), .AGE_W(7)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_op(i_op), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .i_pc(i_pc), .i_imm(i_imm), .i_is_rvc(i_is_rvc), .i_wr_rd(i_wr_rd), .i_pred_taken(i_pred_taken),
    .i_pred_target(i_pred_target), .i_age(i_age), .i_flush(i_flush), .o_wr_valid(o_wr_valid),
    .o_wr_data(o_wr_data), .o_done(o_done), .o_done_age(o_done_age), .o_upd_valid(o_upd_valid),
    .o_upd_taken(o_upd_taken), .o_upd_target(o_upd_target), .o_flush_valid(o_flush_valid),
    .o_flush_age(o_flush_age), .o_flush_target(o_flush_target)
  );
  always #5 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input logic [3:0] op, input logic [63:0] rs1, input logic [63:0] rs2,
                                 input logic [38:0] pc, input logic [31:0] imm, input logic rvc, input logic wr);
    exp_t e;
    logic [63:0] i64, p64, s;
    logic [38:0] tg, ft;
    logic tk;
    i64 = {{32{imm[31]}}, imm};
    p64 = {{25{pc[38]}}, pc};
    case (op)
      4'd0: tk = rs1 == rs2;
      4'd1: tk = rs1 != rs2;
      4'd2: tk = $signed(rs1) < $signed(rs2);
      4'd3: tk = !($signed(rs1) < $signed(rs2));
      4'd4: tk = rs1 < rs2;
      4'd5: tk = !(rs1 < rs2);
      4'd6, 4'd7: tk = 1'b1;
      default: tk = 1'b0;
    endcase
    s = (op == 4'd7) ? rs1 + i64 : p64 + i64;
    tg = (op == 4'd7) ? {s[38:1], 1'b0} : s[38:0];
    ft = pc + (rvc ? 39'd2 : 39'd4);
    e.due = 0;
    e.age = '0;
    e.wr = wr;
    e.wd = (op == 4'd8) ? p64 + i64 : {{25{ft[38]}}, ft};
    e.upd = op != 4'd8;
    e.tk = tk;
    e.tgt = tk ? tg : ft;
    return e;
  endfunction
  task automatic issue(input logic l, input logic [3:0] op, input logic [63:0] rs1, input logic [63:0] rs2,
                       input logic [38:0] pc, input logic [31:0] imm, input logic rvc, input logic wr,
                       input logic pt, input logic [38:0] ptgt, input logic [6:0] age, input logic surv);
    exp_t e;
    i_valid[l] = 1'b1;
    i_op[l] = op;
    i_rs1[l] = rs1;
    i_rs2[l] = rs2;
    i_pc[l] = pc;
    i_imm[l] = imm;
    i_is_rvc[l] = rvc;
    i_wr_rd[l] = wr;
    i_pred_taken[l] = pt;
    i_pred_target[l] = ptgt;
    i_age[l] = age;
    if (surv) begin
      e = model(op, rs1, rs2, pc, imm, rvc, wr);
      e.due = cyc + 2;
      e.age = age;
      if (l) sq1.push_back(e);
      else sq0.push_back(e);
    end
  endtask
  task automatic check_lane(input logic l);
    exp_t e;
    logic have;
    have = l ? (sq1.size() > 0 && sq1[0].due == cyc) : (sq0.size() > 0 && sq0[0].due == cyc);
    chk($sformatf("done_l%0d_c%0d", l, cyc), 64'(o_done[l]), 64'(have));
    if (have && o_done[l]) begin
      e = l ? sq1.pop_front() : sq0.pop_front();
      chk($sformatf("age_l%0d_c%0d", l, cyc), 64'(o_done_age[l]), 64'(e.age));
      chk($sformatf("wr_valid_l%0d_c%0d", l, cyc), 64'(o_wr_valid[l]), 64'(e.wr));
      if (e.wr) chk($sformatf("wr_data_l%0d_c%0d", l, cyc), o_wr_data[l], e.wd);
      chk($sformatf("upd_valid_l%0d_c%0d", l, cyc), 64'(o_upd_valid[l]), 64'(e.upd));
      if (e.upd) begin
        chk($sformatf("upd_taken_l%0d_c%0d", l, cyc), 64'(o_upd_taken[l]), 64'(e.tk));
        chk($sformatf("upd_target_l%0d_c%0d", l, cyc), 64'(o_upd_target[l]), 64'(e.tgt));
      end
    end
  endtask
  task automatic tick(input logic fl);
    @(posedge i_clk);
    #1;
    i_valid = '0;
    i_flush = fl;
    #1;
    cyc++;
    check_lane(1'b0);
    check_lane(1'b1);
  endtask
  initial begin
    // Reset state
    tick(1'b0);
    tick(1'b0);
    i_reset = 1'b0;
    chk("rst_flush_valid", 64'(o_flush_valid), 64'd0);
    chk("rst_wr_valid", 64'(o_wr_valid), 64'd0);
    chk("rst_upd_valid", 64'(o_upd_valid), 64'd0);
    // Single BEQ, correctly predicted taken
    issue(1'b0, 4'd0, 64'd5, 64'd5, 39'h1000, 32'h40, 1'b0, 1'b0, 1'b1, 39'h1040, 7'd3, 1'b1);
    tick(1'b0);
    tick(1'b0);
    chk("beq_taken", 64'(o_upd_taken[0]), 64'd1);
    chk("beq_target", 64'(o_upd_target[0]), 64'h1040);
    chk("beq_done_age", 64'(o_done_age[0]), 64'd3);
    chk("beq_flush_valid", 64'(o_flush_valid), 64'd0);
    // JALR with link, mispredicted target
    issue(1'b1, 4'd7, 64'h2003, 64'd0, 39'h500, 32'd4, 1'b0, 1'b1, 1'b1, 39'h2000, 7'd5, 1'b1);
    tick(1'b0);
    tick(1'b0);
    chk("jalr_wr_data", o_wr_data[1], 64'h504);
    chk("jalr_flush_valid", 64'(o_flush_valid), 64'd1);
    chk("jalr_flush_age", 64'(o_flush_age), 64'd5);
    chk("jalr_flush_target", 64'(o_flush_target), 64'h2006);
    tick(1'b0);
    // Dual mispredict: lane1 age 8 is older than lane0 age 10
    issue(1'b0, 4'd0, 64'd1, 64'd2, 39'h100, 32'h20, 1'b0, 1'b0, 1'b1, 39'h120, 7'd10, 1'b0);
    issue(1'b1, 4'd0, 64'd1, 64'd2, 39'h200, 32'h20, 1'b0, 1'b0, 1'b1, 39'h220, 7'd8, 1'b1);
    tick(1'b0);
    tick(1'b0);
    chk("dual_flush_valid", 64'(o_flush_valid), 64'd1);
    chk("dual_flush_age", 64'(o_flush_age), 64'd8);
    chk("dual_flush_target", 64'(o_flush_target), 64'h204);
    chk("dual_l0_upd_valid", 64'(o_upd_valid[0]), 64'd0);
    tick(1'b0);
    // Squash: JAL age 20 mispredicts in EX2 while EX1 holds age 21; EX0 issues 19 and 22
    issue(1'b0, 4'd6, 64'd0, 64'd0, 39'h400, 32'h100, 1'b0, 1'b1, 1'b0, 39'h0, 7'd20, 1'b1);
    tick(1'b0);
    issue(1'b1, 4'd0, 64'd3, 64'd3, 39'h600, 32'h8, 1'b0, 1'b0, 1'b1, 39'h608, 7'd21, 1'b0);
    tick(1'b0);
    chk("sq_flush_age", 64'(o_flush_age), 64'd20);
    chk("sq_flush_target", 64'(o_flush_target), 64'h500);
    issue(1'b0, 4'd1, 64'd1, 64'd2, 39'h700, 32'h10, 1'b0, 1'b0, 1'b1, 39'h710, 7'd19, 1'b1);
    issue(1'b1, 4'd3, 64'd7, 64'd2, 39'h780, 32'h10, 1'b0, 1'b0, 1'b1, 39'h790, 7'd22, 1'b0);
    tick(1'b0);
    tick(1'b0);
    chk("sq_after_flush_valid", 64'(o_flush_valid), 64'd0);
    tick(1'b0);
    // Wrap-around: flush at 0x7E squashes EX1 age 0x01, keeps EX0 age 0x7D
    issue(1'b0, 4'd6, 64'd0, 64'd0, 39'h800, 32'h40, 1'b1, 1'b1, 1'b0, 39'h0, 7'h7E, 1'b1);
    tick(1'b0);
    issue(1'b1, 4'd0, 64'd9, 64'd9, 39'h900, 32'h8, 1'b0, 1'b0, 1'b1, 39'h908, 7'h01, 1'b0);
    tick(1'b0);
    chk("wrap_flush_age", 64'(o_flush_age), 64'h7E);
    chk("wrap_flush_target", 64'(o_flush_target), 64'h840);
    issue(1'b1, 4'd4, 64'd1, 64'd2, 39'hA00, 32'h30, 1'b0, 1'b0, 1'b1, 39'hA30, 7'h7D, 1'b1);
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    // Global flush with every stage full
    issue(1'b0, 4'd0, 64'd1, 64'd2, 39'hB00, 32'h10, 1'b0, 1'b1, 1'b1, 39'hB10, 7'd30, 1'b0);
    issue(1'b1, 4'd5, 64'd5, 64'd2, 39'hB80, 32'h10, 1'b0, 1'b0, 1'b1, 39'hB90, 7'd31, 1'b0);
    tick(1'b0);
    issue(1'b0, 4'd0, 64'd1, 64'd1, 39'hC00, 32'h10, 1'b0, 1'b0, 1'b1, 39'hC10, 7'd32, 1'b0);
    issue(1'b1, 4'd0, 64'd1, 64'd1, 39'hC80, 32'h10, 1'b0, 1'b0, 1'b1, 39'hC90, 7'd33, 1'b0);
    tick(1'b1);
    chk("fl_flush_valid", 64'(o_flush_valid), 64'd0);
    chk("fl_wr_valid", 64'(o_wr_valid), 64'd0);
    chk("fl_upd_valid", 64'(o_upd_valid), 64'd0);
    issue(1'b0, 4'd0, 64'd1, 64'd1, 39'hD00, 32'h10, 1'b0, 1'b0, 1'b1, 39'hD10, 7'd34, 1'b0);
    issue(1'b1, 4'd0, 64'd1, 64'd1, 39'hD80, 32'h10, 1'b0, 1'b0, 1'b1, 39'hD90, 7'd35, 1'b0);
    tick(1'b0);
    chk("fl_next1_flush_valid", 64'(o_flush_valid), 64'd0);
    tick(1'b0);
    chk("fl_next2_done", 64'(o_done), 64'd0);
    // Reset mid-operation; BLT with negative operand and AUIPC with negative offset complete first
    issue(1'b0, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 39'h900, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b1, 39'h8F0, 7'd40, 1'b1);
    issue(1'b1, 4'd8, 64'd0, 64'd0, 39'h3000, 32'hFFFF_F000, 1'b0, 1'b1, 1'b0, 39'h0, 7'd41, 1'b1);
    tick(1'b0);
    issue(1'b0, 4'd0, 64'd1, 64'd1, 39'hE00, 32'h10, 1'b0, 1'b1, 1'b1, 39'hE10, 7'd42, 1'b0);
    issue(1'b1, 4'd0, 64'd1, 64'd2, 39'hE80, 32'h10, 1'b0, 1'b1, 1'b1, 39'hE90, 7'd43, 1'b0);
    tick(1'b0);
    chk("auipc_wr_data", o_wr_data[1], 64'h2000);
    i_reset = 1'b1;
    issue(1'b0, 4'd0, 64'd1, 64'd1, 39'hF00, 32'h10, 1'b0, 1'b1, 1'b1, 39'hF10, 7'd44, 1'b0);
    issue(1'b1, 4'd0, 64'd1, 64'd1, 39'hF80, 32'h10, 1'b0, 1'b1, 1'b1, 39'hF90, 7'd45, 1'b0);
    tick(1'b0);
    i_reset = 1'b0;
    chk("rst2_wr_valid", 64'(o_wr_valid), 64'd0);
    chk("rst2_upd_valid", 64'(o_upd_valid), 64'd0);
    chk("rst2_flush_valid", 64'(o_flush_valid), 64'd0);
    tick(1'b0);
    tick(1'b0);
    chk("sb0_empty", 64'(sq0.size()), 64'd0);
    chk("sb1_empty", 64'(sq1.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
